// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared helpers for the branch predictor:
//   ctr_max / weak_t / weak_nt : counter constants for a counter of width w
//   ctr_next                   : saturating next value for a counter of width w
// The helpers work on a 32-bit container so one definition serves both the
// narrow per-entry direction counters and the 32-bit perf counter.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int unsigned CNT_CONTAINER_W = 32;

  // All-ones value of a w-bit counter.
  function automatic logic [31:0] ctr_max(input int unsigned w);
    return 32'hFFFF_FFFF >> (32'd32 - w);
  endfunction

  // Weakly-taken: MSB set, remaining bits clear.
  function automatic logic [31:0] weak_t(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Weakly-not-taken: MSB clear, remaining bits set.
  function automatic logic [31:0] weak_nt(input int unsigned w);
    return ctr_max(w) >> 1;
  endfunction

  // Saturating counter step: uncond forces all-ones, taken increments
  // up to all-ones, not-taken decrements down to zero.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr,
                                           input logic        taken,
                                           input logic        uncond,
                                           input int unsigned w);
    logic [31:0] max_v;
    max_v = ctr_max(w);
    if (uncond) begin
      return max_v;
    end else if (taken) begin
      return (ctr >= max_v) ? max_v : ctr + 32'd1;
    end else begin
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
  endfunction

endpackage

// File: rtl/mips_branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit saturating up/down counter with parallel load.
//   clk, rst_b   : clock, asynchronous active-low reset (to RST_VAL)
//   en_i, up_i   : step enable and direction (1 = up)
//   load_i       : load load_val_i (wins over a step)
//   cnt_o        : current count
// -----------------------------------------------------------------------------
module sat_counter
  import mips_pkg::*;
#(
  parameter int unsigned     W       = 2,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority over a saturating step.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = W'(ctr_next(CNT_CONTAINER_W'(cnt_q), up_i, 1'b0, W));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_branch_predictor.sv
// -----------------------------------------------------------------------------
// mips_branch_predictor
// Direct-mapped BTB with per-entry saturating direction counters.
//   clk, rst_b     : clock, asynchronous active-low reset
//   stall          : freezes all state (lookup still follows lk_pc)
//   lk_pc          : fetch PC; lk_hit/lk_taken/lk_next_pc answer combinationally
//                    from registered state (no bypass of a same-cycle update)
//   upd_*          : resolved control-flow outcome from MEM
//   inv            : clear every valid bit (drops a same-cycle update)
//   perf_mispredicts : saturating count of mispredicted updates
// -----------------------------------------------------------------------------
module mips_branch_predictor
  import mips_pkg::*;
#(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              stall,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic              upd_uncond,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              inv,
  output logic [31:0]       perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(weak_nt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

  // Entry view; field widths follow this instance's parameters.
  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [ADDR_W-1:0]   target;
    logic [CTR_BITS-1:0] ctr;
  } btb_entry_t;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_s    [ENTRIES];

  logic [IDX_W-1:0]    lk_idx_s, upd_idx_s;
  logic [TAG_W-1:0]    lk_tag_s, upd_tag_s;
  btb_entry_t          lk_ent_s;
  logic                upd_hit_s, upd_go_s, upd_tk_s, inv_go_s;
  logic                alloc_s, load_s, step_s;
  logic [CTR_BITS-1:0] load_val_s;
  logic                lk_ctr_unused, upd_pc_unused;

  // Lookup: read the indexed entry, compare tag, pick the next fetch PC.
  always_comb begin
    lk_idx_s        = lk_pc[IDX_W+1:2];
    lk_tag_s        = lk_pc[ADDR_W-1:IDX_W+2];
    lk_ent_s.valid  = valid_q[lk_idx_s];
    lk_ent_s.tag    = tag_q[lk_idx_s];
    lk_ent_s.target = target_q[lk_idx_s];
    lk_ent_s.ctr    = ctr_s[lk_idx_s];
    lk_hit          = lk_ent_s.valid & (lk_ent_s.tag == lk_tag_s);
    lk_taken        = lk_hit & lk_ent_s.ctr[CTR_BITS-1];
    if (lk_taken) begin
      lk_next_pc = lk_ent_s.target;
    end else begin
      lk_next_pc = lk_pc + ADDR_W'(4);
    end
  end

  // Only the counter MSB predicts; the byte offset of upd_pc is irrelevant.
  assign lk_ctr_unused = ^lk_ent_s.ctr;
  assign upd_pc_unused = ^upd_pc[1:0];

  // Update decode: hit/allocate/step decisions for the resolved instruction.
  always_comb begin
    upd_idx_s = upd_pc[IDX_W+1:2];
    upd_tag_s = upd_pc[ADDR_W-1:IDX_W+2];
    upd_hit_s = valid_q[upd_idx_s] & (tag_q[upd_idx_s] == upd_tag_s);
    inv_go_s  = inv & ~stall;
    upd_go_s  = upd_valid & ~stall & ~inv;
    upd_tk_s  = upd_taken | upd_uncond;
    alloc_s   = upd_go_s & ~upd_hit_s & upd_tk_s;
    // A hit on an unconditional jump is a load of all-ones, not a step.
    load_s    = alloc_s | (upd_go_s & upd_hit_s & upd_uncond);
    step_s    = upd_go_s & upd_hit_s & ~upd_uncond;
    if (upd_uncond) begin
      load_val_s = CTR_MAX;
    end else begin
      load_val_s = WEAK_T;
    end
  end

  // Valid/tag/target storage; invalidate outranks any same-cycle update.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (inv_go_s) begin
      valid_q <= '0;
    end else if (alloc_s) begin
      valid_q[upd_idx_s]  <= 1'b1;
      tag_q[upd_idx_s]    <= upd_tag_s;
      target_q[upd_idx_s] <= upd_target;
    end else if (upd_go_s & upd_hit_s & upd_tk_s) begin
      target_q[upd_idx_s] <= upd_target;
    end
  end

  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_ctr
    logic sel_s;
    assign sel_s = (upd_idx_s == IDX_W'(g));
    sat_counter #(
      .W       (CTR_BITS),
      .RST_VAL (WEAK_NT)
    ) u_ctr (
      .clk        (clk),
      .rst_b      (rst_b),
      .en_i       (sel_s & step_s),
      .up_i       (upd_taken),
      .load_i     (sel_s & load_s),
      .load_val_i (load_val_s),
      .cnt_o      (ctr_s[g])
    );
  end

  sat_counter #(
    .W       (32),
    .RST_VAL (32'd0)
  ) u_perf (
    .clk        (clk),
    .rst_b      (rst_b),
    .en_i       (upd_valid & upd_mispredict & ~stall),
    .up_i       (1'b1),
    .load_i     (1'b0),
    .load_val_i (32'd0),
    .cnt_o      (perf_mispredicts)
  );

endmodule

// File: tb/tb_mips_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_mips_branch_predictor
// Directed scenarios followed by random traffic. The driver pushes the
// expected lookup/perf response of a reference model into a queue each cycle;
// the monitor pops and compares against the DUT outputs mid-cycle.
// -----------------------------------------------------------------------------
module tb_mips_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CB      = 2;
  localparam int POOL    = 10;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        stall, upd_valid, upd_taken, upd_uncond, upd_mispredict, inv;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_next_pc, perf_mispredicts;

  mips_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CB), .ADDR_W(32)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .stall            (stall),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_taken         (lk_taken),
    .lk_next_pc       (lk_next_pc),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_uncond       (upd_uncond),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .inv              (inv),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  longint      m_perf;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic [31:0] perf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] pool [POOL] = '{32'h40, 32'h440, 32'h80, 32'h84, 32'h1000,
                               32'h1040, 32'hFFFF_FFFC, 32'h3C, 32'h2000_0040, 32'h0};

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  function automatic longint tag_of(logic [31:0] pc);
    return longint'(pc) / (4 * ENTRIES);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 2 ** (CB - 1) - 1;
    end
    m_perf = 0;
  endfunction

  // What the DUT must show now for the current lk_pc.
  function automatic exp_t model_lookup(string nm);
    exp_t e;
    int   i;
    i       = idx_of(lk_pc);
    e.name  = nm;
    e.hit   = m_valid[i] && (m_tag[i] == tag_of(lk_pc));
    e.taken = e.hit && (m_ctr[i] >= 2 ** (CB - 1));
    e.npc   = e.taken ? m_tgt[i] : lk_pc + 32'd4;
    e.perf  = m_perf[31:0];
    return e;
  endfunction

  // Effect of one rising edge with the current inputs.
  function automatic void model_clock();
    int     i;
    longint t;
    bit     tk;
    int     cmax;
    cmax = 2 ** CB - 1;
    if (!rst_b) begin
      m_reset();
      return;
    end
    if (stall) return;
    if (upd_valid && upd_mispredict && m_perf < 64'hFFFF_FFFF) m_perf++;
    if (inv) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      return;
    end
    if (!upd_valid) return;
    i  = idx_of(upd_pc);
    t  = tag_of(upd_pc);
    tk = upd_taken || upd_uncond;
    if (m_valid[i] && m_tag[i] == t) begin
      if (upd_uncond)     m_ctr[i] = cmax;
      else if (upd_taken) m_ctr[i] = (m_ctr[i] + 1 > cmax) ? cmax : m_ctr[i] + 1;
      else                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if (tk) m_tgt[i] = upd_target;
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_tgt[i]   = upd_target;
      m_ctr[i]   = upd_uncond ? cmax : 2 ** (CB - 1);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string nm, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic uu, input logic [31:0] tgt, input logic um,
                      input logic st, input logic iv);
    @(negedge clk);
    lk_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_uncond = uu;
    upd_target = tgt; upd_mispredict = um; stall = st; inv = iv;
    sb_q.push_back(model_lookup(nm));
    @(posedge clk);
    model_clock();
  endtask

  task automatic look(input string nm, input logic [31:0] pc);
    step(nm, pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset pulse in the middle of a cycle that carries an allocating update.
  task automatic reset_pulse();
    @(negedge clk);
    lk_pc = 32'h80; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    upd_uncond = 1'b0; upd_target = 32'h200; upd_mispredict = 1'b1;
    stall = 1'b0; inv = 1'b0;
    #1 rst_b = 1'b0;
    m_reset();
    sb_q.push_back(model_lookup("rst_async"));
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // ---------------- monitor ----------------
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".hit"},   {31'd0, lk_hit},   {31'd0, e.hit});
        chk({e.name, ".taken"}, {31'd0, lk_taken}, {31'd0, e.taken});
        chk({e.name, ".npc"},   lk_next_pc,        e.npc);
        chk({e.name, ".perf"},  perf_mispredicts,  e.perf);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_b = 1'b0; stall = 1'b0; inv = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    upd_uncond = 1'b0; upd_mispredict = 1'b0; lk_pc = 32'h40; upd_pc = 32'd0;
    upd_target = 32'd0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // 1: post-reset lookup
    look("t1_reset", 32'h40);

    // 2: allocate, then walk the counter down and check it floors at zero
    step("t2_alloc", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0);
    look("t2_hit", 32'h40);
    step("t2_nt1", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step("t2_nt2", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("t2_weak", 32'h40);
    step("t2_nt3", 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("t2_tk", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0);
    look("t2_floor", 32'h40);

    // 3: aliasing at the same index
    step("t3_a", 32'h440, 1'b1, 32'h440, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0, 1'b0);
    look("t3_old", 32'h40);
    look("t3_new", 32'h440);

    // 4: same-cycle lookup and first allocation return pre-update state
    step("t4_same", 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    look("t4_next", 32'h80);

    // 5: stall freezes everything, then the held inputs apply
    for (int k = 0; k < 3; k++)
      step("t5_stall", 32'h80, 1'b1, 32'h40, 1'b1, 1'b0, 32'h700, 1'b1, 1'b1, 1'b1);
    step("t5_go", 32'h80, 1'b1, 32'h40, 1'b1, 1'b0, 32'h700, 1'b1, 1'b0, 1'b1);
    look("t5_inv", 32'h80);

    // 6: perf saturation, inv retains perf, async reset clears it
    @(negedge clk);
    force dut.u_perf.cnt_q = 32'hFFFF_FFFE;
    m_perf = 64'hFFFF_FFFE;
    look("t6_preload", 32'h80);
    #1 release dut.u_perf.cnt_q;
    for (int k = 0; k < 3; k++)
      step("t6_sat", 32'h80, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h900, 1'b1, 1'b0, 1'b0);
    step("t6_inv", 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    look("t6_miss", 32'h1000);
    step("t6_alloc", 32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h880, 1'b0, 1'b0, 1'b0);
    look("t6_hit", 32'h80);
    reset_pulse();
    look("t6_abort", 32'h40);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lp, up;
      lp = pool[$urandom_range(0, POOL - 1)] + 32'($urandom_range(0, 3));
      up = pool[$urandom_range(0, POOL - 1)] + 32'($urandom_range(0, 3));
      step("rand", lp, 1'($urandom_range(0, 9) < 6), up, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), $urandom(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0));
    end

    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_branch_predictor.md
Name: mips_branch_predictor

Overview:
Parametrised direct-mapped branch target buffer (BTB) with saturating-counter direction prediction for the pipelined MIPS core.
- Fetch queries it every cycle with the current PC and gets a predicted next PC. Today's behaviour of "assume PC+4, flush on resolve" becomes a fallback for misses and mispredicts.
- The MEM stage writes back resolved branch, jump and jr outcomes.
- Also keeps a saturating mispredict performance counter.

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, 2..256.
- CTR_BITS, 2: width of each direction counter; 1..4.
- ADDR_W, 32: PC width.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline stall (cache not ready); blocks update, invalidate and perf counting
- lk_pc  in  ADDR_W  fetch PC to look up
- lk_hit  out  1  valid entry whose tag matches lk_pc
- lk_taken  out  1  predicted taken
- lk_next_pc  out  ADDR_W  predicted next fetch PC
- upd_valid  in  1  resolved control-flow instruction present in MEM
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_uncond  in  1  j/jal/jr (always taken)
- upd_target  in  ADDR_W  actual target
- upd_mispredict  in  1  fetch prediction for this instruction was wrong (direction or target)
- inv  in  1  invalidate all entries
- perf_mispredicts  out  32  saturating mispredict count

Behaviour:
- IDX_W = log2(ENTRIES).
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target, and a CTR_BITS counter.

Lookup (combinational from registered state, 0-cycle latency):
- lk_hit = valid[idx] & (tag[idx] == lk_tag).
- lk_taken = lk_hit & ctr[idx][MSB].
- lk_next_pc = lk_taken ? target[idx] : lk_pc + 4. Arithmetic is modulo 2^ADDR_W.

Update (registered; takes effect at the posedge where upd_valid & ~stall & ~inv):
- Hit at upd_pc:
  - Taken: counter saturating increment, never above all-ones; target <= upd_target.
  - Not taken: counter saturating decrement, never below 0; target unchanged.
  - upd_uncond: counter forced to all-ones.
- Miss, taken (or uncond): allocate, overwriting any existing entry at that index.
  - valid=1, tag, target written.
  - Counter = all-ones if uncond, else weakly-taken (1 followed by zeros).
- Miss, not taken: no change.

Simultaneous events:
- Lookup and update at the same index in the same cycle: lookup returns pre-update contents. There is no write-through bypass.
- inv & ~stall: all valid bits clear at the next posedge. inv has priority over a same-cycle update; that update is dropped.
- stall=1: no state changes at all. Lookup outputs still track lk_pc.

Perf counter:
- Increments on upd_valid & upd_mispredict & ~stall.
- Saturates at 32'hFFFF_FFFF; it does not wrap.
- Not cleared by inv.

Reset (asynchronous, rst_b low):
- All valid=0; counters = weakly-not-taken (0 followed by ones); tags and targets = 0; perf_mispredicts=0.
- Outputs during reset: lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+4.
- Reset asserted mid-update aborts that update; no partial entry is written.

Decomposition:
- Shared package mips_pkg holds:
  - btb_entry_t struct (valid, tag, target, ctr).
  - Function ctr_next(ctr, taken, uncond) for saturating arithmetic.
  - Localparams for reset counter values: WEAK_NT, WEAK_T, CTR_MAX.
- One natural sub-module, sat_counter: CTR_BITS-wide saturating up/down counter with load. It is instantiated per entry; a widened instance also serves the perf counter.
- Tag compare and next-PC mux stay in the top module.

Test Plan:
1. Reset, then lk_pc=0x40 -> lk_hit=0, lk_taken=0, lk_next_pc=0x44; perf_mispredicts=0.
2. Update pc=0x40, taken, target=0x100, then lookup 0x40 -> hit=1, taken=1, next_pc=0x100. After two not-taken updates -> taken=0, next_pc=0x44. After a third not-taken -> counter stays at 0.
3. Aliasing with ENTRIES=16: allocate 0x40 (taken), then a taken update at 0x440 (same index, different tag) -> lookup 0x40 misses; lookup 0x440 hits with the new target.
4. Same-cycle lookup and update at 0x80 (first allocation) -> lookup that cycle misses; lookup the next cycle hits.
5. stall=1 held 3 cycles with upd_valid=1, upd_mispredict=1, inv=1 -> entries and perf counter unchanged; they apply once stall drops.
6. Preload perf counter to 0xFFFF_FFFE, apply 3 mispredict updates -> reads 0xFFFF_FFFF. Then inv -> all lookups miss, perf value retained. Then rst_b pulse mid-cycle -> immediate clear without a clock edge.
